// File: rtl/io_counter_unit_if.sv
// Control/status bundle for io_counter_unit: the master drives the control
// fields and the counter (slave) returns count and the status flags.
interface io_counter_unit_if #(
  parameter int WIDTH = 42,
  parameter int PRE_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] compare;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             match;
  logic             ovf;

  modport master (
    output en, mode, dir, load, load_val, prescale, compare, clr_ovf,
    input  count, tick, match, ovf
  );

  modport slave (
    input  en, mode, dir, load, load_val, prescale, compare, clr_ovf,
    output count, tick, match, ovf
  );
endinterface

// File: rtl/io_counter_unit.sv
// Prescaled up/down/saturating counter with a tick pulse, compare match and
// a sticky overflow flag.
module io_counter_unit #(
  parameter int WIDTH = 42,
  parameter int PRE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  io_counter_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_DIR  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] count_q;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_q;
  logic             ovf_q;

  logic             step;
  logic             step_up;
  logic             saturate;
  logic             wrap_set;
  logic [WIDTH-1:0] count_next;

  // Using >= means a prescale lowered below pre_cnt steps on the next enabled edge.
  assign step = bus.en && (pre_cnt >= bus.prescale);

  always_comb begin
    step_up    = 1'b1;
    saturate   = 1'b0;
    wrap_set   = 1'b0;
    count_next = count_q;
    case (mode_e'(bus.mode))
      MODE_UP:   step_up = 1'b1;
      MODE_DOWN: step_up = 1'b0;
      MODE_SAT: begin
        step_up  = 1'b1;
        saturate = 1'b1;
      end
      MODE_DIR:  step_up = bus.dir;
      default:   step_up = 1'b1;
    endcase
    if (step_up) begin
      if (count_q == '1) begin
        wrap_set   = 1'b1;
        count_next = saturate ? count_q : '0;
      end else begin
        count_next = count_q + 1'b1;
      end
    end else begin
      if (count_q == '0) begin
        wrap_set   = 1'b1;
        count_next = '1;
      end else begin
        count_next = count_q - 1'b1;
      end
    end
  end

  // Reset beats load, load beats stepping; a set event beats clr_ovf.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      pre_cnt <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
      pre_cnt <= '0;
      tick_q  <= 1'b0;
      if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end else begin
      tick_q <= step;
      if (step) begin
        pre_cnt <= '0;
        count_q <= count_next;
      end else if (bus.en) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (step && wrap_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.ovf   = ovf_q;
  assign bus.match = (count_q == bus.compare);

endmodule
